// File: rtl/fpu_pkg.sv
// Shared FPU definitions: multiplier timing, tag width,
// writeback entry layout and a few FP bit patterns.
package fpu_pkg;

  localparam int FMUL_LATENCY = 2;
  localparam int FMUL_OVF_LAT = 1;
  localparam int FPU_TAGW     = 6;

  localparam logic [31:0] ZERO = 32'h0000_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  typedef struct packed {
    logic [31:0]         data;
    logic                ovf;
    logic [FPU_TAGW-1:0] tag;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous show-ahead FIFO with flush.
// Head entry is visible on rdata whenever count != 0.
module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 39,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          do_pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign rdata  = mem[rp];

  // Storage, wrapping pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + AW'(1);
      end
      if (do_pop)
        rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Upstream credit gating must make this impossible.
  always_ff @(posedge clk) begin
    if (rstn && !flush)
      assert (!(push && full));
  end

endmodule

// File: rtl/fmul_wb_queue.sv
// Tracks in-flight FP multiplies and queues their
// results for writeback with credit-gated issue.
module fmul_wb_queue import fpu_pkg::*; #(
  parameter  int LATENCY = FMUL_LATENCY,
  parameter  int OVF_LAT = FMUL_OVF_LAT,
  parameter  int DEPTH   = 4,
  parameter  int TAGW    = FPU_TAGW,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [TAGW-1:0] in_tag,
  output logic            in_ready,
  input  logic [31:0]     mul_y,
  input  logic            mul_ovf,
  output logic            out_valid,
  output logic [31:0]     out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_ovf,
  input  logic            out_ready,
  output logic [CW-1:0]   count
);

  localparam int EW = 33 + TAGW;
  localparam int OD = LATENCY - OVF_LAT;
  localparam int SW = 16;

  logic [LATENCY-1:0] v;
  logic [TAGW-1:0]    tg [LATENCY];
  logic               fire;
  logic               push;
  logic               pop;
  logic               ovf_al;
  logic               empty;
  logic [SW-1:0]      inflight;
  logic [EW-1:0]      rd;

  assign fire = in_valid & in_ready;
  assign push = v[LATENCY-1];
  assign pop  = out_valid & out_ready;

  // Valid/tag pipe mirroring the multiplier latency.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v <= '0;
      for (int i = 0; i < LATENCY; i++)
        tg[i] <= '0;
    end else begin
      v[0]  <= fire & ~flush;
      tg[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        v[i]  <= v[i-1] & ~flush;
        tg[i] <= tg[i-1];
      end
    end
  end

  if (OD == 0) begin : g_ovf_direct
    assign ovf_al = mul_ovf;
  end else begin : g_ovf_pipe
    logic [OD-1:0] od;

    // Delay the early overflow flag to product timing.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        od <= '0;
      end else begin
        od[0] <= mul_ovf;
        for (int i = 1; i < OD; i++)
          od[i] <= od[i-1];
      end
    end

    assign ovf_al = od[OD-1];
  end

  // Count results already committed to the pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + SW'(v[i]);
  end

  assign in_ready = (SW'(count) + inflight) < SW'(DEPTH);

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (push),
    .wdata ({mul_y, ovf_al, tg[LATENCY-1]}),
    .pop   (pop),
    .rdata (rd),
    .count (count),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign {out_data, out_ovf, out_tag} = rd;

endmodule

// File: tb/tb_fmul_wb_queue.sv
// Bench: behavioural 2-stage multiplier feeding fmul_wb_queue,
// directed sequences plus a queue-based reference model.
module tb_fmul_wb_queue;
  import fpu_pkg::*;

  localparam int LAT = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready;
  logic [5:0]  in_tag, out_tag;
  logic [31:0] x1, x2, mul_y, out_data;
  logic        mul_ovf, out_valid, out_ovf, out_ready;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fmul_wb_queue dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .mul_y     (mul_y),
    .mul_ovf   (mul_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .count     (count)
  );

  // Truncating normal-only FP multiply: {ovf, product}.
  function automatic logic [32:0] fm(input logic [31:0] a,
                                     input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'h0 || b[30:23] == 8'h0)
      return {1'b0, s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {1'b1, s, PINF[30:0]};
    if (e <= 0) return {1'b0, s, ZERO[30:0]};
    return {1'b0, s, e[7:0], m};
  endfunction

  logic [32:0] s1;
  logic [31:0] s2;

  always @(posedge clk) begin
    s1 <= fm(x1, x2);
    s2 <= s1[31:0];
  end

  assign mul_ovf = s1[32];
  assign mul_y   = s2;

  typedef struct {
    wb_entry_t e;
    int        rem;
  } pend_t;

  pend_t     pend[$];
  wb_entry_t vis[$];
  wb_entry_t seen[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Advance the reference model over one clock, then compare.
  task automatic tick();
    bit          mf;
    pend_t       p;
    logic [32:0] r;
    mf = rstn && !flush && in_valid && (vis.size() + pend.size() < DEP);
    if (out_valid && out_ready && rstn && !flush)
      seen.push_back('{data: out_data, ovf: out_ovf, tag: out_tag});
    if (!rstn || flush) begin
      pend.delete();
      vis.delete();
    end else begin
      if (out_ready && vis.size() > 0) void'(vis.pop_front());
      foreach (pend[i]) pend[i].rem--;
      while (pend.size() > 0 && pend[0].rem == 0) begin
        p = pend.pop_front();
        vis.push_back(p.e);
      end
      if (mf) begin
        r = fm(x1, x2);
        p.e = '{data: r[31:0], ovf: r[32], tag: in_tag};
        p.rem = LAT;
        pend.push_back(p);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(vis.size() != 0));
    chk("count", 32'(count), 32'(vis.size()));
    chk("in_ready", 32'(in_ready), 32'(vis.size() + pend.size() < DEP));
    if (vis.size() > 0) begin
      chk("out_data", out_data, vis[0].data);
      chk("out_tag", 32'(out_tag), 32'(vis[0].tag));
      chk("out_ovf", 32'(out_ovf), 32'(vis[0].ovf));
    end
  endtask

  function automatic logic [31:0] rop();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h0;
    if (k == 1)
      return {1'($urandom), 8'($urandom_range(200, 254)), 23'($urandom)};
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] y;
    logic        ovf;
  } vec_t;

  initial begin
    vec_t vt [5];
    int   nf;
    bit   fired;

    vt[0] = '{32'h4000_0000, 32'h4040_0000, 6'd5, 32'h40C0_0000, 1'b0};
    vt[1] = '{32'h7F00_0000, 32'h7F00_0000, 6'd1, 32'h7F80_0000, 1'b1};
    vt[2] = '{32'h0000_0000, 32'h4000_0000, 6'd2, 32'h0000_0000, 1'b0};
    vt[3] = '{32'h3F80_0000, 32'hC000_0000, 6'd9, 32'hC000_0000, 1'b0};
    vt[4] = '{32'h4040_0000, 32'h4040_0000, 6'd3, 32'h4110_0000, 1'b0};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_tag = '0;
    out_ready = 1'b0; x1 = '0; x2 = '0;
    tick();
    tick();
    rstn = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1; in_valid = 1'b1; in_tag = 6'd5;
    x1 = 32'h4000_0000; x2 = 32'h4040_0000;
    tick();
    in_valid = 1'b0; x1 = $urandom; x2 = $urandom;
    chk("single_c1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single_c2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single_c3_valid", 32'(out_valid), 32'd1);
    chk("single_c3_data", out_data, 32'h40C0_0000);
    chk("single_c3_tag", 32'(out_tag), 32'd5);
    chk("single_c3_ovf", 32'(out_ovf), 32'd0);
    tick();
    chk("single_c4_count", 32'(count), 32'd0);
    chk("single_c4_valid", 32'(out_valid), 32'd0);

    seen.delete();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; x1 = vt[i].a; x2 = vt[i].b; in_tag = vt[i].tag;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    chk("vec_n", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      chk("vec_data", seen[i].data, vt[i].y);
      chk("vec_ovf", 32'(seen[i].ovf), 32'(vt[i].ovf));
      chk("vec_tag", 32'(seen[i].tag), 32'(vt[i].tag));
    end

    out_ready = 1'b0; in_valid = 1'b1; nf = 0;
    for (int c = 0; c < 8; c++) begin
      in_tag = 6'(nf); x1 = rop(); x2 = rop();
      fired = in_ready;
      if (c == 4) chk("bp_ready_c4", 32'(in_ready), 32'd0);
      if (c == 6) chk("bp_count_c6", 32'(count), 32'd4);
      tick();
      if (fired) nf++;
    end
    chk("bp_fires", 32'(nf), 32'd4);
    seen.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_ready_c8", 32'(in_ready), 32'd0);
    tick();
    chk("bp_ready_c9", 32'(in_ready), 32'd1);
    repeat (4) tick();
    chk("bp_n", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      chk("bp_tag", 32'(seen[i].tag), 32'(i));

    seen.delete();
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_tag = 6'(c + 10); x1 = rop(); x2 = rop();
      tick();
      chk("stream_cnt_le1", 32'(count <= 3'd1), 32'd1);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    chk("stream_n", 32'(seen.size()), 32'd20);
    for (int i = 0; i < 20 && i < seen.size(); i++)
      chk("stream_tag", 32'(seen[i].tag), 32'(i + 10));

    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_tag = 6'(20 + c); x1 = rop(); x2 = rop();
      tick();
    end
    in_valid = 1'b0;
    chk("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    seen.delete();
    repeat (4) tick();
    chk("fl_killed", 32'(seen.size()), 32'd0);
    in_valid = 1'b1; in_tag = 6'd42; x1 = rop(); x2 = rop();
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("fl_next_n", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("fl_next_tag", 32'(seen[0].tag), 32'd42);

    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_tag = 6'(50 + c); x1 = rop(); x2 = rop();
      tick();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 6'd33;
    x1 = 32'h3F80_0000; x2 = 32'hC000_0000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mr_c3_valid", 32'(out_valid), 32'd1);
    chk("mr_c3_data", out_data, 32'hC000_0000);
    chk("mr_c3_tag", 32'(out_tag), 32'd33);
    tick();

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_tag    = 6'($urandom);
      x1        = rop();
      x2        = rop();
      out_ready = ((n / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                       : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 60) == 0);
      rstn      = ($urandom_range(0, 250) != 0);
      tick();
    end
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    chk("final_count", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
